// File: rtl/aemb_fsl_fifo.sv
// FSL slave bridge: a core-side level-handshake port feeding two 33-bit {ctl,data} FIFOs,
// TXQ (core PUT to m-side stream) and RXQ (s-side stream to core GET).

module aemb_fsl_fifo_q #(
    parameter int AW = 4
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        push_i,
    input  logic [32:0] dat_i,
    input  logic        pop_i,
    output logic [32:0] dat_o,
    output logic        full_o,
    output logic        empty_o
);
    localparam logic [AW:0]   CNT_ONE = 1;
    localparam logic [AW-1:0] PTR_ONE = 1;

    logic [32:0]   mem_q [2**AW];
    logic [AW-1:0] wr_q;
    logic [AW-1:0] rd_q;
    logic [AW:0]   cnt_q;
    logic          do_push;
    logic          do_pop;

    // Count never exceeds 2^AW, so its top bit alone means full.
    assign full_o  = cnt_q[AW];
    assign empty_o = (cnt_q == '0);
    assign dat_o   = mem_q[rd_q];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + PTR_ONE;
            if (do_pop)  rd_q <= rd_q + PTR_ONE;
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + CNT_ONE;
                2'b01:   cnt_q <= cnt_q - CNT_ONE;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_q] <= dat_i;
    end
endmodule

module aemb_fsl_fifo #(
    parameter int CH = 0,
    parameter int AW = 4
) (
    input  logic        sys_clk_i,
    input  logic        sys_rst_i,
    input  logic [6:2]  fsl_adr_i,
    input  logic [1:0]  fsl_tag_i,
    input  logic        fsl_stb_i,
    input  logic        fsl_wre_i,
    input  logic [31:0] fsl_dat_i,
    output logic        fsl_ack_o,
    output logic [31:0] fsl_dat_o,
    output logic        fsl_ctl_o,
    input  logic [31:0] s_dat_i,
    input  logic        s_ctl_i,
    input  logic        s_vld_i,
    output logic        s_rdy_o,
    output logic [31:0] m_dat_o,
    output logic        m_ctl_o,
    output logic        m_vld_o,
    input  logic        m_rdy_i
);
    typedef enum logic {ST_IDLE, ST_ACK} state_t;

    state_t      state_q, state_d;
    logic [31:0] dat_q, dat_d;
    logic        ctl_q, ctl_d;
    logic        tx_push, tx_full, tx_empty;
    logic        rx_pop, rx_full, rx_empty;
    logic [32:0] tx_head, rx_head;
    logic        hit;
    logic        unused_tag;

    assign unused_tag = fsl_tag_i[1];
    assign hit        = (fsl_adr_i == 5'(CH));

    aemb_fsl_fifo_q #(.AW(AW)) u_txq (
        .clk_i   (sys_clk_i),
        .rst_ni  (sys_rst_i),
        .push_i  (tx_push),
        .dat_i   ({fsl_tag_i[0], fsl_dat_i}),
        .pop_i   (m_rdy_i),
        .dat_o   (tx_head),
        .full_o  (tx_full),
        .empty_o (tx_empty)
    );

    aemb_fsl_fifo_q #(.AW(AW)) u_rxq (
        .clk_i   (sys_clk_i),
        .rst_ni  (sys_rst_i),
        .push_i  (s_vld_i),
        .dat_i   ({s_ctl_i, s_dat_i}),
        .pop_i   (rx_pop),
        .dat_o   (rx_head),
        .full_o  (rx_full),
        .empty_o (rx_empty)
    );

    assign s_rdy_o   = !rx_full;
    assign m_vld_o   = !tx_empty;
    assign m_dat_o   = tx_head[31:0];
    assign m_ctl_o   = tx_head[32];
    assign fsl_ack_o = (state_q == ST_ACK);
    assign fsl_dat_o = dat_q;
    assign fsl_ctl_o = ctl_q;

    always_ff @(posedge sys_clk_i or negedge sys_rst_i) begin
        if (!sys_rst_i) begin
            state_q <= ST_IDLE;
            dat_q   <= '0;
            ctl_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            dat_q   <= dat_d;
            ctl_q   <= ctl_d;
        end
    end

    // An access that cannot complete stays in IDLE and is retried every cycle the core stalls.
    always_comb begin
        state_d = state_q;
        dat_d   = dat_q;
        ctl_d   = ctl_q;
        tx_push = 1'b0;
        rx_pop  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (fsl_stb_i) begin
                    if (!hit) begin
                        state_d = ST_ACK;
                        if (!fsl_wre_i) begin
                            dat_d = '0;
                            ctl_d = 1'b0;
                        end
                    end else if (fsl_wre_i) begin
                        if (!tx_full) begin
                            tx_push = 1'b1;
                            state_d = ST_ACK;
                        end
                    end else if (!rx_empty) begin
                        rx_pop  = 1'b1;
                        dat_d   = rx_head[31:0];
                        ctl_d   = rx_head[32];
                        state_d = ST_ACK;
                    end
                end
            end
            ST_ACK: begin
                if (!fsl_stb_i) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end
endmodule

// File: tb/tb_aemb_fsl_fifo.sv
// Directed self-checking bench for aemb_fsl_fifo (CH=0, AW=4).
module tb_aemb_fsl_fifo;
   logic        sys_clk_i = 1'b0;
   logic        sys_rst_i;
   logic [6:2]  fsl_adr_i;
   logic [1:0]  fsl_tag_i;
   logic        fsl_stb_i;
   logic        fsl_wre_i;
   logic [31:0] fsl_dat_i;
   logic        fsl_ack_o;
   logic [31:0] fsl_dat_o;
   logic        fsl_ctl_o;
   logic [31:0] s_dat_i;
   logic        s_ctl_i;
   logic        s_vld_i;
   logic        s_rdy_o;
   logic [31:0] m_dat_o;
   logic        m_ctl_o;
   logic        m_vld_o;
   logic        m_rdy_i;

   int nChecks = 0;
   int nErrors = 0;
   int cycles;

   aemb_fsl_fifo #(.CH(0), .AW(4)) dut (
      .sys_clk_i (sys_clk_i),
      .sys_rst_i (sys_rst_i),
      .fsl_adr_i (fsl_adr_i),
      .fsl_tag_i (fsl_tag_i),
      .fsl_stb_i (fsl_stb_i),
      .fsl_wre_i (fsl_wre_i),
      .fsl_dat_i (fsl_dat_i),
      .fsl_ack_o (fsl_ack_o),
      .fsl_dat_o (fsl_dat_o),
      .fsl_ctl_o (fsl_ctl_o),
      .s_dat_i   (s_dat_i),
      .s_ctl_i   (s_ctl_i),
      .s_vld_i   (s_vld_i),
      .s_rdy_o   (s_rdy_o),
      .m_dat_o   (m_dat_o),
      .m_ctl_o   (m_ctl_o),
      .m_vld_o   (m_vld_o),
      .m_rdy_i   (m_rdy_i)
   );

   // Free-running 100 MHz clock
   always #5 sys_clk_i = ~sys_clk_i;

   // Count one comparison and report any mismatch
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      nChecks++;
      if (observed !== expected) begin
         nErrors++;
         $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   // Advance to just after the next rising edge, where outputs are sampled and inputs driven
   task automatic tick;
      @(posedge sys_clk_i);
      #1;
   endtask

   // One complete core access: raise stb, wait (bounded) for ack, drop stb, let ack fall
   task automatic applyStimulus(input logic wre, input logic [4:0] adr, input logic [1:0] tag,
                                input logic [31:0] dat, input int budget, output int nCyc);
      fsl_stb_i = 1'b1;
      fsl_wre_i = wre;
      fsl_adr_i = adr;
      fsl_tag_i = tag;
      fsl_dat_i = dat;
      nCyc = -1;
      for (int i = 1; i <= budget; i++) begin
         tick();
         if (fsl_ack_o) begin
            nCyc = i;
            break;
         end
      end
      fsl_stb_i = 1'b0;
      tick();
   endtask

   // Main directed sequence
   initial begin
      sys_rst_i = 1'b0;
      fsl_adr_i = '0;
      fsl_tag_i = '0;
      fsl_stb_i = 1'b0;
      fsl_wre_i = 1'b0;
      fsl_dat_i = '0;
      s_dat_i   = '0;
      s_ctl_i   = 1'b0;
      s_vld_i   = 1'b0;
      m_rdy_i   = 1'b0;
      repeat (3) tick();
      checkOutput("rst_ack", 32'(fsl_ack_o), 32'd0);
      checkOutput("rst_dat", fsl_dat_o, 32'd0);
      checkOutput("rst_ctl", 32'(fsl_ctl_o), 32'd0);
      checkOutput("rst_srdy", 32'(s_rdy_o), 32'd1);
      checkOutput("rst_mvld", 32'(m_vld_o), 32'd0);
      sys_rst_i = 1'b1;
      tick();

      // Single PUT shows up on the m-side
      applyStimulus(1'b1, 5'd0, 2'b01, 32'hDEADBEEF, 50, cycles);
      checkOutput("put1_lat", 32'(cycles), 32'd1);
      checkOutput("put1_ackdrop", 32'(fsl_ack_o), 32'd0);
      checkOutput("put1_mvld", 32'(m_vld_o), 32'd1);
      checkOutput("put1_mdat", m_dat_o, 32'hDEADBEEF);
      checkOutput("put1_mctl", 32'(m_ctl_o), 32'd1);
      m_rdy_i = 1'b1;
      tick();
      m_rdy_i = 1'b0;
      checkOutput("put1_drained", 32'(m_vld_o), 32'd0);

      // PUT to another channel acks but leaves TXQ empty
      applyStimulus(1'b1, 5'd7, 2'b01, 32'h11111111, 50, cycles);
      checkOutput("putx_lat", 32'(cycles), 32'd1);
      checkOutput("putx_mvld", 32'(m_vld_o), 32'd0);

      // Fill TXQ, block a 17th PUT, free one slot, drain in order
      for (int i = 0; i < 16; i++) begin
         applyStimulus(1'b1, 5'd0, {1'b0, i[0]}, 32'hA0000000 + 32'(i), 50, cycles);
         checkOutput("fill_lat", 32'(cycles), 32'd1);
      end
      fsl_stb_i = 1'b1;
      fsl_wre_i = 1'b1;
      fsl_adr_i = 5'd0;
      fsl_tag_i = 2'b00;
      fsl_dat_i = 32'hA0000010;
      for (int i = 0; i < 3; i++) begin
         tick();
         checkOutput("full_ack", 32'(fsl_ack_o), 32'd0);
      end
      checkOutput("full_head", m_dat_o, 32'hA0000000);
      m_rdy_i = 1'b1;
      tick();
      m_rdy_i = 1'b0;
      checkOutput("pulse_ack", 32'(fsl_ack_o), 32'd0);
      tick();
      checkOutput("p17_ack", 32'(fsl_ack_o), 32'd1);
      fsl_stb_i = 1'b0;
      tick();
      m_rdy_i = 1'b1;
      for (int i = 1; i <= 16; i++) begin
         checkOutput("drain_vld", 32'(m_vld_o), 32'd1);
         checkOutput("drain_dat", m_dat_o, 32'hA0000000 + 32'(i));
         checkOutput("drain_ctl", 32'(m_ctl_o), 32'(i[0]));
         tick();
      end
      m_rdy_i = 1'b0;
      checkOutput("drain_empty", 32'(m_vld_o), 32'd0);

      // GET waits on an empty RXQ until the s-side supplies a word
      fsl_stb_i = 1'b1;
      fsl_wre_i = 1'b0;
      fsl_adr_i = 5'd0;
      for (int i = 0; i < 5; i++) begin
         tick();
         checkOutput("getwait_ack", 32'(fsl_ack_o), 32'd0);
      end
      s_vld_i = 1'b1;
      s_dat_i = 32'h12345678;
      s_ctl_i = 1'b0;
      tick();
      s_vld_i = 1'b0;
      checkOutput("getpush_ack", 32'(fsl_ack_o), 32'd0);
      tick();
      checkOutput("getwait_ack1", 32'(fsl_ack_o), 32'd1);
      checkOutput("getwait_dat", fsl_dat_o, 32'h12345678);
      checkOutput("getwait_ctl", 32'(fsl_ctl_o), 32'd0);
      fsl_stb_i = 1'b0;
      tick();

      // Off-channel GET returns zero, then held GET pops exactly one word
      s_vld_i = 1'b1;
      s_dat_i = 32'hCAFEF00D;
      s_ctl_i = 1'b1;
      tick();
      s_dat_i = 32'h00C0FFEE;
      s_ctl_i = 1'b0;
      tick();
      s_vld_i = 1'b0;
      applyStimulus(1'b0, 5'd3, 2'b00, 32'h0, 50, cycles);
      checkOutput("getx_lat", 32'(cycles), 32'd1);
      checkOutput("getx_dat", fsl_dat_o, 32'd0);
      checkOutput("getx_ctl", 32'(fsl_ctl_o), 32'd0);
      fsl_stb_i = 1'b1;
      fsl_wre_i = 1'b0;
      fsl_adr_i = 5'd0;
      tick();
      checkOutput("hold_ack", 32'(fsl_ack_o), 32'd1);
      checkOutput("hold_dat0", fsl_dat_o, 32'hCAFEF00D);
      checkOutput("hold_ctl0", 32'(fsl_ctl_o), 32'd1);
      repeat (3) tick();
      checkOutput("hold_dat3", fsl_dat_o, 32'hCAFEF00D);
      fsl_stb_i = 1'b0;
      tick();
      applyStimulus(1'b0, 5'd0, 2'b00, 32'h0, 50, cycles);
      checkOutput("get2_lat", 32'(cycles), 32'd1);
      checkOutput("get2_dat", fsl_dat_o, 32'h00C0FFEE);
      checkOutput("get2_ctl", 32'(fsl_ctl_o), 32'd0);

      // RXQ full: simultaneous GET and s-side push, push must be refused
      for (int i = 0; i < 16; i++) begin
         s_vld_i = 1'b1;
         s_dat_i = 32'hB0000000 + 32'(i);
         s_ctl_i = i[0];
         tick();
      end
      checkOutput("rxfull_srdy", 32'(s_rdy_o), 32'd0);
      s_dat_i = 32'h00000BAD;
      s_ctl_i = 1'b1;
      fsl_stb_i = 1'b1;
      fsl_wre_i = 1'b0;
      fsl_adr_i = 5'd0;
      tick();
      s_vld_i = 1'b0;
      checkOutput("rxfull_ack", 32'(fsl_ack_o), 32'd1);
      checkOutput("rxfull_dat", fsl_dat_o, 32'hB0000000);
      checkOutput("rxfull_srdy1", 32'(s_rdy_o), 32'd1);
      fsl_stb_i = 1'b0;
      tick();
      for (int i = 1; i < 16; i++) begin
         applyStimulus(1'b0, 5'd0, 2'b00, 32'h0, 50, cycles);
         checkOutput("rxd_lat", 32'(cycles), 32'd1);
         checkOutput("rxd_dat", fsl_dat_o, 32'hB0000000 + 32'(i));
         checkOutput("rxd_ctl", 32'(fsl_ctl_o), 32'(i[0]));
      end
      applyStimulus(1'b0, 5'd0, 2'b00, 32'h0, 20, cycles);
      checkOutput("rx_nobad", 32'(cycles), 32'hFFFFFFFF);

      // Asynchronous reset while an ack is held with three words in TXQ
      applyStimulus(1'b1, 5'd0, 2'b00, 32'hC0000000, 50, cycles);
      applyStimulus(1'b1, 5'd0, 2'b00, 32'hC0000001, 50, cycles);
      fsl_stb_i = 1'b1;
      fsl_wre_i = 1'b1;
      fsl_dat_i = 32'hC0000002;
      tick();
      checkOutput("prerst_ack", 32'(fsl_ack_o), 32'd1);
      checkOutput("prerst_mvld", 32'(m_vld_o), 32'd1);
      #2;
      sys_rst_i = 1'b0;
      #1;
      checkOutput("rst_ack_async", 32'(fsl_ack_o), 32'd0);
      checkOutput("rst_mvld_async", 32'(m_vld_o), 32'd0);
      checkOutput("rst_srdy_async", 32'(s_rdy_o), 32'd1);
      checkOutput("rst_dat_async", fsl_dat_o, 32'd0);
      fsl_stb_i = 1'b0;
      tick();
      sys_rst_i = 1'b1;
      tick();
      checkOutput("postrst_ack", 32'(fsl_ack_o), 32'd0);
      checkOutput("postrst_mvld", 32'(m_vld_o), 32'd0);
      applyStimulus(1'b1, 5'd0, 2'b00, 32'h00000055, 50, cycles);
      checkOutput("postrst_lat", 32'(cycles), 32'd1);
      checkOutput("postrst_mdat", m_dat_o, 32'h00000055);
      m_rdy_i = 1'b1;
      tick();
      m_rdy_i = 1'b0;
      checkOutput("postrst_one", 32'(m_vld_o), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
      $finish;
   end
endmodule
